// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the instruction-memory side of the CPU:
// ROM word width and the response-routing states of the ROM port arbiter.
package cpu_mem_pkg;

    localparam int ROM_WORD_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_IF_RSP = 2'd1,
        ARB_LS_RSP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rom_arb_starve_cnt.sv
// Starvation counter for the load/debug port: counts consecutive denied
// cycles and raises force_ls once the wait has reached MAX_WAIT.
module rom_arb_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic ls_req,
    input  logic ls_gnt,
    output logic force_ls
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    // Saturates at the limit so the forced grant stays pending until taken.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wait_cnt <= 4'd0;
        end else if (!ls_req || ls_gnt) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign force_ls = (wait_cnt == WAIT_LIMIT);

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the combinational instruction ROM between fetch (IF) and the
// load/debug port (LS). Address checking is built only with ROM_ARB_ERR_CHK_EN.
module rom_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DEPTH    = 7,
    parameter int MAX_WAIT = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  if_req_i,
    input  logic [AW-1:0]         if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [ROM_WORD_W-1:0] if_rdata_o,
    output logic                  if_err_o,
    input  logic                  ls_req_i,
    input  logic [AW-1:0]         ls_addr_i,
    output logic                  ls_gnt_o,
    output logic                  ls_rvalid_o,
    output logic [ROM_WORD_W-1:0] ls_rdata_o,
    output logic                  ls_err_o,
    output logic [AW-1:0]         rom_addr_o,
    input  logic [ROM_WORD_W-1:0] rom_data_i
);

    if (DEPTH < 1 || MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_params
        $error("rom_port_arbiter: DEPTH must be >= 1 and MAX_WAIT within 1..15");
    end

    arb_state_e            state;
    arb_state_e            state_nxt;
    logic                  force_ls;
    logic                  if_gnt;
    logic                  ls_gnt;
    logic [AW-1:0]         gnt_addr;
    logic                  gnt_err;
    logic [AW-1:0]         addr_q;
    logic                  err_q;
    logic [ROM_WORD_W-1:0] if_rdata_q;
    logic [ROM_WORD_W-1:0] ls_rdata_q;

    rom_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .ls_req   (ls_req_i),
        .ls_gnt   (ls_gnt),
        .force_ls (force_ls)
    );

    // IF has priority unless LS has waited long enough; nothing is granted in reset.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!sys_rst) begin
            if (ls_req_i && (!if_req_i || force_ls)) begin
                ls_gnt = 1'b1;
            end else if (if_req_i) begin
                if_gnt = 1'b1;
            end
        end
        gnt_addr = ls_gnt ? ls_addr_i : if_addr_i;
    end

    always_comb begin
`ifdef ROM_ARB_ERR_CHK_EN
        gnt_err = gnt_addr[0] || ({1'b0, gnt_addr[AW-1:1]} >= AW'(DEPTH));
`else
        gnt_err = 1'b0;
`endif
    end

    assign if_gnt_o   = if_gnt;
    assign ls_gnt_o   = ls_gnt;
    assign rom_addr_o = (if_gnt || ls_gnt) ? gnt_addr : addr_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The grant of this cycle alone decides who receives the response next cycle.
    always_comb begin
        state_nxt   = ARB_IDLE;
        if_rvalid_o = 1'b0;
        ls_rvalid_o = 1'b0;
        if_err_o    = 1'b0;
        ls_err_o    = 1'b0;
        if (ls_gnt) begin
            state_nxt = ARB_LS_RSP;
        end else if (if_gnt) begin
            state_nxt = ARB_IF_RSP;
        end
        case (state)
            ARB_IF_RSP: begin
                if_rvalid_o = 1'b1;
                if_err_o    = err_q;
            end
            ARB_LS_RSP: begin
                ls_rvalid_o = 1'b1;
                ls_err_o    = err_q;
            end
            default: ;
        endcase
    end

    // Errored accesses return zero data; the loser's data register keeps its value.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            addr_q     <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else if (if_gnt || ls_gnt) begin
            addr_q <= gnt_addr;
            err_q  <= gnt_err;
            if (ls_gnt) begin
                ls_rdata_q <= gnt_err ? '0 : rom_data_i;
            end else begin
                if_rdata_q <= gnt_err ? '0 : rom_data_i;
            end
        end
    end

    assign if_rdata_o = if_rdata_q;
    assign ls_rdata_o = ls_rdata_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed scenarios pinned by
// literal values, then randomized traffic checked against a queue-based model.
module tb_rom_port_arbiter;

    localparam int AW       = 16;
    localparam int DEPTH    = 7;
    localparam int MAX_WAIT = 4;

    typedef struct {
        bit          is_ls;
        bit          err;
        logic [15:0] data;
    } rsp_t;

    logic          sys_clk;
    logic          sys_rst;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [15:0]   if_rdata_o;
    logic          if_err_o;
    logic          ls_req_i;
    logic [AW-1:0] ls_addr_i;
    logic          ls_gnt_o;
    logic          ls_rvalid_o;
    logic [15:0]   ls_rdata_o;
    logic          ls_err_o;
    logic [AW-1:0] rom_addr_o;
    logic [15:0]   rom_data_i;

    int            n_tests = 0;
    int            n_fail  = 0;

    int            m_wait;
    rsp_t          rsp_q[$];
    logic [15:0]   m_if_rdata;
    logic [15:0]   m_ls_rdata;
    logic [AW-1:0] m_last_addr;
    bit            exp_if_gnt;
    bit            exp_ls_gnt;

    rom_port_arbiter #(
        .AW       (AW),
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .if_err_o    (if_err_o),
        .ls_req_i    (ls_req_i),
        .ls_addr_i   (ls_addr_i),
        .ls_gnt_o    (ls_gnt_o),
        .ls_rvalid_o (ls_rvalid_o),
        .ls_rdata_o  (ls_rdata_o),
        .ls_err_o    (ls_err_o),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // ROM contents: word n = 16'h5CCD + n * 16'h0101 (word 0 = 5CCD, 1 = 5DCE, 2 = 5ECF).
    function automatic logic [15:0] rom_word(input logic [AW-1:0] a);
        logic [15:0] idx;
        idx = a >> 1;
        return 16'h5CCD + idx * 16'h0101;
    endfunction

    assign rom_data_i = rom_word(rom_addr_o);

    function automatic bit exp_err(input logic [AW-1:0] a);
`ifdef ROM_ARB_ERR_CHK_EN
        return (a[0] == 1'b1) || (int'(a >> 1) >= DEPTH);
`else
        return (a === 16'hxxxx);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait      = 0;
        rsp_q.delete();
        m_if_rdata  = '0;
        m_ls_rdata  = '0;
        m_last_addr = '0;
        exp_if_gnt  = 1'b0;
        exp_ls_gnt  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " if_gnt"},    32'(if_gnt_o),    0);
        check({tag, " ls_gnt"},    32'(ls_gnt_o),    0);
        check({tag, " if_rvalid"}, 32'(if_rvalid_o), 0);
        check({tag, " ls_rvalid"}, 32'(ls_rvalid_o), 0);
        check({tag, " if_err"},    32'(if_err_o),    0);
        check({tag, " ls_err"},    32'(ls_err_o),    0);
        check({tag, " if_rdata"},  32'(if_rdata_o),  0);
        check({tag, " ls_rdata"},  32'(ls_rdata_o),  0);
        check({tag, " rom_addr"},  32'(rom_addr_o),  0);
    endtask

    // Drive one cycle's requests away from the rising edge, then let comb logic settle.
    task automatic applyStimulus(input bit ir, input logic [AW-1:0] ia,
                                 input bit lr, input logic [AW-1:0] la);
        @(negedge sys_clk);
        if_req_i  = ir;
        if_addr_i = ia;
        ls_req_i  = lr;
        ls_addr_i = la;
        #1;
    endtask

    // Compare every output with the model, then advance the model across the next edge.
    task automatic checkOutput();
        rsp_t        rsp;
        bit          have_rsp;
        logic [AW-1:0] gaddr;
        exp_ls_gnt = ls_req_i && (!if_req_i || m_wait >= MAX_WAIT);
        exp_if_gnt = if_req_i && !exp_ls_gnt;
        gaddr      = exp_ls_gnt ? ls_addr_i : (exp_if_gnt ? if_addr_i : m_last_addr);
        have_rsp   = rsp_q.size() > 0;
        if (have_rsp) begin
            rsp = rsp_q.pop_front();
            if (rsp.is_ls) m_ls_rdata = rsp.data;
            else           m_if_rdata = rsp.data;
        end else begin
            rsp = '{is_ls: 1'b0, err: 1'b0, data: 16'h0};
        end
        check("if_gnt",    32'(if_gnt_o),    32'(exp_if_gnt));
        check("ls_gnt",    32'(ls_gnt_o),    32'(exp_ls_gnt));
        check("rom_addr",  32'(rom_addr_o),  32'(gaddr));
        check("if_rvalid", 32'(if_rvalid_o), 32'(have_rsp && !rsp.is_ls));
        check("ls_rvalid", 32'(ls_rvalid_o), 32'(have_rsp && rsp.is_ls));
        check("if_err",    32'(if_err_o),    32'(have_rsp && !rsp.is_ls && rsp.err));
        check("ls_err",    32'(ls_err_o),    32'(have_rsp && rsp.is_ls && rsp.err));
        check("if_rdata",  32'(if_rdata_o),  32'(m_if_rdata));
        check("ls_rdata",  32'(ls_rdata_o),  32'(m_ls_rdata));
        if (exp_if_gnt || exp_ls_gnt) begin
            rsp.is_ls   = exp_ls_gnt;
            rsp.err     = exp_err(gaddr);
            rsp.data    = rsp.err ? 16'h0 : rom_word(gaddr);
            rsp_q.push_back(rsp);
            m_last_addr = gaddr;
        end
        if (ls_req_i && !exp_ls_gnt) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
        else                         m_wait = 0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        if_req_i = 1'b1;
        ls_req_i = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            #1;
            check_all_zero("reset");
            @(negedge sys_clk);
        end
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        sys_rst  = 1'b0;
        model_reset();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return AW'($urandom_range(0, DEPTH - 1) * 2);
            2:       return AW'($urandom_range(0, 31));
            default: return AW'($urandom);
        endcase
    endfunction

    initial begin
        bit            if_act, ls_act;
        logic [AW-1:0] if_a, ls_a;
        sys_rst   = 1'b1;
        if_req_i  = 1'b0;
        if_addr_i = '0;
        ls_req_i  = 1'b0;
        ls_addr_i = '0;
        model_reset();
        #1;
        check_all_zero("por");
        do_reset(2);

        // Single fetch of word 0.
        applyStimulus(1, 16'h0000, 0, 16'h0000);
        check("first if_gnt", 32'(if_gnt_o), 1);
        checkOutput();
        applyStimulus(0, 16'h0000, 0, 16'h0000);
        check("first if_rvalid", 32'(if_rvalid_o), 1);
        check("first if_rdata",  32'(if_rdata_o),  32'h5CCD);
        check("first if_err",    32'(if_err_o),    0);
        checkOutput();

        // Back-to-back fetch stream.
        applyStimulus(1, 16'h0000, 0, 16'h0000); checkOutput();
        applyStimulus(1, 16'h0002, 0, 16'h0000);
        check("stream rdata0", 32'(if_rdata_o), 32'h5CCD);
        checkOutput();
        applyStimulus(1, 16'h0004, 0, 16'h0000);
        check("stream rdata1", 32'(if_rdata_o), 32'h5DCE);
        checkOutput();
        applyStimulus(0, 16'h0000, 0, 16'h0000);
        check("stream rvalid2", 32'(if_rvalid_o), 1);
        check("stream rdata2",  32'(if_rdata_o),  32'h5ECF);
        checkOutput();

        // Starvation: both requesting, LS forced every fifth cycle.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 16'h0002, 1, 16'h0004);
            check("starve ls_gnt", 32'(ls_gnt_o), 32'(i % 5 == 4));
            checkOutput();
        end

        // LS misaligned and out-of-range reads.
        applyStimulus(0, 16'h0000, 1, 16'h0003); checkOutput();
        applyStimulus(0, 16'h0000, 1, 16'h000E);
        check("ls 0003 rvalid", 32'(ls_rvalid_o), 1);
`ifdef ROM_ARB_ERR_CHK_EN
        check("ls 0003 err",   32'(ls_err_o),   1);
        check("ls 0003 rdata", 32'(ls_rdata_o), 0);
`else
        check("ls 0003 err",   32'(ls_err_o),   0);
        check("ls 0003 rdata", 32'(ls_rdata_o), 32'h5DCE);
`endif
        checkOutput();
        applyStimulus(0, 16'h0000, 0, 16'h0000);
`ifdef ROM_ARB_ERR_CHK_EN
        check("ls 000E err", 32'(ls_err_o), 1);
`else
        check("ls 000E err", 32'(ls_err_o), 0);
`endif
        checkOutput();

        // Reset during a granted fetch: the response must never appear.
        applyStimulus(1, 16'h0006, 0, 16'h0000);
        checkOutput();
        do_reset(3);
        applyStimulus(0, 16'h0000, 0, 16'h0000);
        check("post-reset if_rvalid", 32'(if_rvalid_o), 0);
        checkOutput();

        // Randomized traffic with legal early withdrawals and one reset.
        if_act = 0; ls_act = 0; if_a = '0; ls_a = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (exp_if_gnt) if_act = 0;
            if (exp_ls_gnt) ls_act = 0;
            if (!if_act && $urandom_range(0, 2) != 0) begin
                if_act = 1; if_a = rand_addr();
            end else if (if_act && $urandom_range(0, 15) == 0) begin
                if_act = 0;
            end
            if (!ls_act && $urandom_range(0, 2) == 0) begin
                ls_act = 1; ls_a = rand_addr();
            end else if (ls_act && $urandom_range(0, 15) == 0) begin
                ls_act = 0;
            end
            if (cyc == 200) begin
                do_reset(2);
                if_act = 0; ls_act = 0;
            end
            applyStimulus(if_act, if_a, ls_act, ls_a);
            checkOutput();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single combinational-read instruction ROM between two requesters: instruction fetch (IF) and the load/debug port (LS).
- Fixed priority to IF, with a starvation counter that forces an LS grant after a bounded wait.
- Registers ROM read data and returns it one cycle after grant.
- Sits between the CPU fetch stage / debug loader and the rom block; drives the ROM byte address.

Parameters:
- AW, 16: byte-address width on all ports.
- DEPTH, 7: number of 16-bit ROM words; used for the range check.
- MAX_WAIT, 4: consecutive cycles LS may be denied before it is forced; range 1..15.

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch request; addr held stable until if_gnt_o
- if_addr_i  in  AW  fetch byte address
- if_gnt_o  out  1  fetch granted this cycle (combinational)
- if_rvalid_o  out  1  fetch data valid (one-cycle pulse)
- if_rdata_o  out  16  fetch data
- if_err_o  out  1  fetch access error, qualified by if_rvalid_o
- ls_req_i  in  1  LS request; addr held stable until ls_gnt_o
- ls_addr_i  in  AW  LS byte address
- ls_gnt_o  out  1  LS granted this cycle
- ls_rvalid_o  out  1  LS data valid pulse
- ls_rdata_o  out  16  LS data
- ls_err_o  out  1  LS access error, qualified by ls_rvalid_o
- rom_addr_o  out  AW  byte address to ROM (ROM uses addr>>1)
- rom_data_i  in  16  combinational ROM read data

Behaviour:
- Reset values: all gnt/rvalid/err outputs 0, rdata 0, rom_addr_o 0, wait counter 0, state IDLE.
- Grant selection each cycle (combinational):
  - LS is granted if ls_req_i && (!if_req_i || wait_cnt == MAX_WAIT).
  - Otherwise IF is granted if if_req_i.
  - At most one gnt per cycle.
- rom_addr_o = address of the granted requester; otherwise holds the last granted address (registered mux select, no glitch to 0).
- Data path:
  - On the posedge ending a grant cycle, rom_data_i is captured into the winner's rdata register.
  - The winner's rvalid is asserted for exactly one cycle (latency 1).
  - Non-winner rdata registers hold their previous value.
  - Throughput: one access per cycle; back-to-back grants give back-to-back rvalid.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle ls_req_i is high and LS is not granted.
  - Clears on LS grant or when ls_req_i is low.
- State machine:
  - IDLE: no grant last cycle.
  - IF_RSP: response pending to IF.
  - LS_RSP: response pending to LS.
  - The next state is determined solely by this cycle's grant. The state drives the rvalid/err routing.
- Error:
  - err = addr[0] (misaligned) || (addr>>1) >= DEPTH.
  - On error, the access is still granted; rvalid pulses with err = 1 and rdata = 0.
- Simultaneous requests with wait_cnt < MAX_WAIT: IF wins. At MAX_WAIT, LS wins exactly once, then the counter clears.
- Deasserting a request before grant is legal; no response is generated.
- Reset mid-access: the pending rvalid is dropped and no response is delivered after reset.

Optional Feature:
- ROM_ARB_ERR_CHK_EN defined: misaligned/range checking as above.
- Undefined:
  - No checking; every access returns ROM data.
  - if_err_o and ls_err_o are tied 0.
  - DEPTH is unused.

Decomposition:
- Shared package (cpu_mem_pkg): state encoding localparams (ARB_IDLE = 2'd0, ARB_IF_RSP = 2'd1, ARB_LS_RSP = 2'd2) and ROM_WORD_W = 16.
- One natural sub-module: rom_arb_starve_cnt (saturating wait counter plus force flag).

Test Plan:
- Reset, then IF reads addr 0x0000 -> gnt the same cycle; next cycle if_rvalid_o = 1, if_rdata_o = 16'h5CCD, err = 0.
- IF streams 0x0000, 0x0002, 0x0004 back-to-back -> three consecutive rvalid pulses carrying words 0, 1, 2.
- IF and LS both held high continuously, MAX_WAIT = 4 -> LS is granted on the 5th cycle, then IF resumes; the pattern repeats every 5 cycles.
- LS reads 0x0003 -> ls_rvalid_o = 1, ls_err_o = 1, ls_rdata_o = 0. LS reads 0x000E (word 7 >= DEPTH) -> err = 1.
- Without ROM_ARB_ERR_CHK_EN, LS reads 0x0003 -> err = 0, data = word 1.
- sys_rst asserted the cycle after an IF grant -> no if_rvalid_o pulse; all outputs 0 while reset is held.
